// File: rtl/display_matrix_scan.sv
// LED-matrix scan driver: row multiplexing, per-frame shadow registers,
// cursor blink, inter-row blanking and PWM brightness for a ROWS x COLS matrix.
module display_matrix_scan #(
    parameter int ROWS         = 5,
    parameter int COLS         = 7,
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYC    = 500,
    parameter int BRIGHT_W     = 3,
    parameter int BLINK_FRAMES = 50,
    parameter int ROW_ACT      = 1,
    parameter int COL_ACT      = 1
) (
    input  logic                     CLOCK_50,
    input  logic                     rst_n,
    input  logic [1:0]               mode,
    input  logic [BRIGHT_W-1:0]      bright,
    input  logic [ROWS*COLS-1:0]     pixels,
    input  logic [ROWS*COLS-1:0]     cursor,
    output logic [ROWS-1:0]          row,
    output logic [COLS-1:0]          column,
    output logic                     frame_start
);

    localparam int SLOT_W = $clog2(SCAN_DIV);
    localparam int ROW_W  = $clog2(ROWS);
    localparam int FC_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
    localparam logic [SLOT_W-1:0] BLANK_END = SLOT_W'(BLANK_CYC);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(ROWS - 1);
    localparam logic [FC_W-1:0]   FC_LAST   = FC_W'(BLINK_FRAMES - 1);

    // XOR masks turning "on" vectors into pin levels
    localparam logic [ROWS-1:0] ROW_IDLE = (ROW_ACT != 0) ? '0 : '1;
    localparam logic [COLS-1:0] COL_IDLE = (COL_ACT != 0) ? '0 : '1;

    typedef enum logic [1:0] {
        MODE_OFF       = 2'b00,
        MODE_NORMAL    = 2'b01,
        MODE_BLINK_OR  = 2'b10,
        MODE_BLINK_XOR = 2'b11
    } mode_t;

    logic [SLOT_W-1:0]    slot_cnt;
    logic [ROW_W-1:0]     row_idx;
    logic [FC_W-1:0]      frame_cnt;
    logic                 blink_phase;
    logic [BRIGHT_W-1:0]  pwm_cnt;

    logic [ROWS*COLS-1:0] sh_pixels;
    logic [ROWS*COLS-1:0] sh_cursor;
    mode_t                sh_mode;
    logic [BRIGHT_W-1:0]  sh_bright;

    logic                 fs;
    logic                 slot_last;
    logic                 row_last;
    logic                 blink_wrap;
    mode_t                eff_mode;
    logic [COLS-1:0]      row_pix;
    logic [COLS-1:0]      row_cur;
    logic [COLS-1:0]      lit;
    logic [COLS-1:0]      col_on;
    logic [ROWS-1:0]      row_sel;
    logic [ROWS-1:0]      row_on;

    // Counter terminal conditions and frame-start detection
    always_comb begin
        slot_last  = (slot_cnt == SLOT_LAST);
        row_last   = (row_idx == ROW_LAST);
        blink_wrap = (frame_cnt == FC_LAST);
        fs         = (slot_cnt == '0) && (row_idx == '0);
    end

    // Row slot timer and row index
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt <= '0;
            row_idx  <= '0;
        end else if (slot_last) begin
            slot_cnt <= '0;
            row_idx  <= row_last ? '0 : row_idx + 1'b1;
        end else begin
            slot_cnt <= slot_cnt + 1'b1;
        end
    end

    // Free-running PWM phase counter
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

    // Frame snapshot of inputs and blink timebase, updated only at frame start
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            sh_pixels   <= '0;
            sh_cursor   <= '0;
            sh_mode     <= MODE_OFF;
            sh_bright   <= '0;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (fs) begin
            sh_pixels <= pixels;
            sh_cursor <= cursor;
            sh_mode   <= mode_t'(mode);
            sh_bright <= bright;
            if (blink_wrap) begin
                frame_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    // Select the current row's pixel and cursor bits plus its one-hot line
    always_comb begin
        row_pix = '0;
        row_cur = '0;
        row_sel = '0;
        for (int unsigned r = 0; r < ROWS; r++) begin
            if (row_idx == ROW_W'(r)) begin
                row_pix    = sh_pixels[r*COLS +: COLS];
                row_cur    = sh_cursor[r*COLS +: COLS];
                row_sel[r] = 1'b1;
            end
        end
    end

    // Pixel function, blanking/PWM gating and row enable
    always_comb begin
        lit = '0;
        case (sh_mode)
            MODE_OFF:       lit = '0;
            MODE_NORMAL:    lit = row_pix;
            MODE_BLINK_OR:  lit = row_pix | (row_cur & {COLS{blink_phase}});
            MODE_BLINK_XOR: lit = row_pix ^ (row_cur & {COLS{blink_phase}});
            default:        lit = '0;
        endcase

        col_on = '0;
        if ((slot_cnt >= BLANK_END) && (pwm_cnt <= sh_bright)) begin
            col_on = lit;
        end

        // The shadow mode is still stale in the frame-start cycle, so the row
        // line uses the value being captured; columns are blanked there anyway.
        eff_mode = fs ? mode_t'(mode) : sh_mode;
        row_on   = (eff_mode == MODE_OFF) ? '0 : row_sel;
    end

    // Registered pin drivers and frame-start pulse
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            row         <= ROW_IDLE;
            column      <= COL_IDLE;
            frame_start <= 1'b0;
        end else begin
            row         <= row_on ^ ROW_IDLE;
            column      <= col_on ^ COL_IDLE;
            frame_start <= fs;
        end
    end

endmodule

// File: tb/tb_display_matrix_scan.sv
// Scoreboard bench for display_matrix_scan: the stimulus process pushes the
// hand-computed per-frame expectation; the monitor pops one at each
// frame_start and checks every cycle of that frame.
module tb_display_matrix_scan;

    localparam int ROWS = 3;
    localparam int COLS = 4;
    localparam int SCAN_DIV = 8;
    localparam int BLANK_CYC = 2;
    localparam int BRIGHT_W = 2;
    localparam int BLINK_FRAMES = 2;
    localparam int FRAME = ROWS * SCAN_DIV;
    localparam int NVEC = 15;

    logic                 CLOCK_50 = 1'b0;
    logic                 rst_n;
    logic [1:0]           mode;
    logic [BRIGHT_W-1:0]  bright;
    logic [ROWS*COLS-1:0] pixels;
    logic [ROWS*COLS-1:0] cursor;
    logic [ROWS-1:0]      row;
    logic [COLS-1:0]      column;
    logic                 frame_start;

    display_matrix_scan #(
        .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV), .BLANK_CYC(BLANK_CYC),
        .BRIGHT_W(BRIGHT_W), .BLINK_FRAMES(BLINK_FRAMES), .ROW_ACT(1), .COL_ACT(1)
    ) dut (
        .CLOCK_50(CLOCK_50), .rst_n(rst_n), .mode(mode), .bright(bright),
        .pixels(pixels), .cursor(cursor), .row(row), .column(column),
        .frame_start(frame_start)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Inputs for one frame plus the expected active-window columns per row
    typedef struct {
        logic [1:0]  mode;
        logic [1:0]  bright;
        logic [11:0] pixels;
        logic [11:0] cursor;
        logic [3:0]  c0;
        logic [3:0]  c1;
        logic [3:0]  c2;
        logic        off;
    } vec_t;

    vec_t vecs[NVEC];
    vec_t sb[$];
    vec_t cur;

    int   errors = 0;
    int   checks = 0;
    logic mon_en = 1'b0;
    int   p = 0;
    bit   active = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic apply(input vec_t v);
        mode   = v.mode;
        bright = v.bright;
        pixels = v.pixels;
        cursor = v.cursor;
    endtask

    task automatic wait_fs(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 4 * FRAME && !seen; i++) begin
            @(negedge CLOCK_50);
            if (frame_start === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s: frame_start not seen within %0d cycles", tag, 4 * FRAME);
        end
    endtask

    // Monitor: per-frame scoreboard check on every falling edge
    always @(negedge CLOCK_50) begin
        int r, s;
        logic [3:0] cw, exp_col;
        logic [2:0] exp_row;
        if (!mon_en) begin
            active = 1'b0;
        end else begin
            if (active) begin
                p++;
                check("frame_start_timing", {31'd0, frame_start}, {31'd0, p == FRAME});
                if (p >= FRAME && frame_start !== 1'b1) active = 1'b0;
            end
            if (frame_start === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard_underflow: frame_start with no expected frame at %0t", $time);
                    active = 1'b0;
                end else begin
                    cur = sb.pop_front();
                    p = 0;
                    active = 1'b1;
                end
            end
            if (active) begin
                r = p / SCAN_DIV;
                s = p % SCAN_DIV;
                cw = (r == 0) ? cur.c0 : (r == 1) ? cur.c1 : cur.c2;
                exp_row = cur.off ? 3'b000 : (3'b001 << r);
                exp_col = (cur.off || s < BLANK_CYC || (p % 4) > int'(cur.bright)) ? 4'h0 : cw;
                check("row", {29'd0, row}, {29'd0, exp_row});
                check("column", {28'd0, column}, {28'd0, exp_col});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Blink phase of frame k (k=1 first after reset) is (k/2)&1:
        // frames 4,5 off / 6,7 on; frames 8,9 off / 10,11 on.
        vecs[0]  = '{2'b01, 2'd3, 12'hA5C, 12'h000, 4'hC, 4'h5, 4'hA, 1'b0};
        vecs[1]  = '{2'b01, 2'd3, 12'hA5C, 12'h000, 4'hC, 4'h5, 4'hA, 1'b0};
        vecs[2]  = '{2'b01, 2'd3, 12'hFFF, 12'h000, 4'hF, 4'hF, 4'hF, 1'b0};
        vecs[3]  = '{2'b10, 2'd3, 12'h000, 12'h001, 4'h0, 4'h0, 4'h0, 1'b0};
        vecs[4]  = '{2'b10, 2'd3, 12'h000, 12'h001, 4'h0, 4'h0, 4'h0, 1'b0};
        vecs[5]  = '{2'b10, 2'd3, 12'h000, 12'h001, 4'h1, 4'h0, 4'h0, 1'b0};
        vecs[6]  = '{2'b10, 2'd3, 12'h000, 12'h001, 4'h1, 4'h0, 4'h0, 1'b0};
        vecs[7]  = '{2'b11, 2'd3, 12'h00F, 12'h003, 4'hF, 4'h0, 4'h0, 1'b0};
        vecs[8]  = '{2'b11, 2'd3, 12'h00F, 12'h003, 4'hF, 4'h0, 4'h0, 1'b0};
        vecs[9]  = '{2'b11, 2'd3, 12'h00F, 12'h003, 4'hC, 4'h0, 4'h0, 1'b0};
        vecs[10] = '{2'b11, 2'd3, 12'h00F, 12'h003, 4'hC, 4'h0, 4'h0, 1'b0};
        vecs[11] = '{2'b01, 2'd1, 12'hFFF, 12'h000, 4'hF, 4'hF, 4'hF, 1'b0};
        vecs[12] = '{2'b00, 2'd3, 12'hFFF, 12'h000, 4'h0, 4'h0, 4'h0, 1'b1};
        vecs[13] = '{2'b01, 2'd0, 12'hFFF, 12'h000, 4'hF, 4'hF, 4'hF, 1'b0};
        vecs[14] = '{2'b01, 2'd3, 12'hFFF, 12'h000, 4'hF, 4'hF, 4'hF, 1'b0};

        rst_n = 1'b1;
        apply(vecs[0]);
        #1 rst_n = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        check("reset_row", {29'd0, row}, 32'd0);
        check("reset_column", {28'd0, column}, 32'd0);
        check("reset_frame_start", {31'd0, frame_start}, 32'd0);

        mon_en = 1'b1;
        sb.push_back(vecs[0]);
        rst_n = 1'b1;
        @(posedge CLOCK_50) #1;
        check("release_frame_start", {31'd0, frame_start}, 32'd1);
        check("release_row", {29'd0, row}, 32'd1);

        for (int k = 1; k < NVEC; k++) begin
            wait_fs("frame_start_wait");
            // Frame 2: change the picture mid-frame; it must not show before frame 3
            if (k == 2) repeat (10) @(negedge CLOCK_50);
            apply(vecs[k]);
            sb.push_back(vecs[k]);
        end

        // Last frame: assert reset asynchronously in the middle of row 1
        wait_fs("frame_start_wait");
        repeat (12) @(negedge CLOCK_50);
        @(posedge CLOCK_50) #1 mon_en = 1'b0;
        check("pre_reset_column", {28'd0, column}, 32'hF);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_row", {29'd0, row}, 32'd0);
        check("async_reset_column", {28'd0, column}, 32'd0);
        check("async_reset_frame_start", {31'd0, frame_start}, 32'd0);
        sb.delete();
        repeat (2) @(negedge CLOCK_50);
        check("held_reset_row", {29'd0, row}, 32'd0);

        apply(vecs[0]);
        sb.push_back(vecs[0]);
        rst_n = 1'b1;
        @(posedge CLOCK_50) #1 mon_en = 1'b1;
        check("rerelease_frame_start", {31'd0, frame_start}, 32'd1);
        check("rerelease_row", {29'd0, row}, 32'd1);
        wait_fs("frame_start_wait");
        sb.push_back(vecs[1]);
        wait_fs("frame_start_wait");
        repeat (FRAME - 1) @(negedge CLOCK_50);
        @(posedge CLOCK_50) #1 mon_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
